// File: rtl/ps2_space_decoder.sv
// PS/2 set-2 receiver: frames bytes off the keyboard lines and decodes space/ESC for the Dino game.
// Latency: byte_valid 3 clk after the raw stop-bit falling edge; SpaceFlag/space_pulse/esc_pulse 1 clk later.
// Backpressure: none; PS/2 is a push-only source, so every byte and error is presented as a one-cycle pulse.
module ps2_space_decoder #(
    parameter logic [7:0] SPACE_CODE     = 8'h29,
    parameter logic [7:0] ESC_CODE       = 8'h76,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       SpaceFlag,
    output logic       space_pulse,
    output logic       esc_pulse
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // synchronizer stages; s3 holds the previous synced clock for edge detection
    logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic             space_flag_q, space_flag_d;
    logic             space_pulse_q, space_pulse_d;
    logic             esc_pulse_q, esc_pulse_d;

    logic fall;
    logic din;

    assign fall = clk_s3_q & ~clk_s2_q;
    assign din  = dat_s2_q;

    // synchronizer next-state: plain shift of the raw pins
    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        clk_s3_d = clk_s2_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;
    end

    // frame FSM: start/data/parity/stop on synced falling edges, with inactivity timeout
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tcnt_d       = tcnt_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            // an edge always wins over a timeout landing in the same cycle
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = din;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (din && ((^shift_q) ^ parity_q)) begin
                        rx_byte_d    = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_IDLE) begin
            tcnt_d = '0;
        end else if (tcnt_q == CNT_LAST) begin
            // abandon the partial frame; break/extended prefixes survive
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tcnt_d      = '0;
        end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end
    end

    // scan-code decode of each good byte: prefix tracking, space level/pulse, ESC pulse
    always_comb begin
        brk_d         = brk_q;
        ext_d         = ext_q;
        space_flag_d  = space_flag_q;
        space_pulse_d = 1'b0;
        esc_pulse_d   = 1'b0;
        if (byte_valid_q) begin
            if (rx_byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                if (!ext_q && rx_byte_q == SPACE_CODE) begin
                    space_flag_d  = !brk_q;
                    // typematic repeats arrive with the flag already set, so no pulse
                    space_pulse_d = !brk_q && !space_flag_q;
                end
                if (!ext_q && !brk_q && rx_byte_q == ESC_CODE) begin
                    esc_pulse_d = 1'b1;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    // state registers; synchronizers reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_s3_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            state_q       <= S_IDLE;
            bitcnt_q      <= 3'd0;
            shift_q       <= 8'd0;
            parity_q      <= 1'b0;
            tcnt_q        <= '0;
            rx_byte_q     <= 8'd0;
            byte_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            space_flag_q  <= 1'b0;
            space_pulse_q <= 1'b0;
            esc_pulse_q   <= 1'b0;
        end else begin
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_s3_q      <= clk_s3_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tcnt_q        <= tcnt_d;
            rx_byte_q     <= rx_byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_err_q   <= frame_err_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            space_flag_q  <= space_flag_d;
            space_pulse_q <= space_pulse_d;
            esc_pulse_q   <= esc_pulse_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign rx_byte     = rx_byte_q;
    assign frame_err   = frame_err_q;
    assign SpaceFlag   = space_flag_q;
    assign space_pulse = space_pulse_q;
    assign esc_pulse   = esc_pulse_q;

endmodule

// File: doc/ps2_space_decoder.md
Name: ps2_space_decoder

Overview:
- Upstream input stage for the Dino game. Receives PS/2 keyboard frames and decodes set-2 scan codes.
- Produces the level SpaceFlag consumed by the Dino sprite/jump logic, a one-cycle jump request pulse, and an Escape pulse used as a breakGameFlag source.
- Runs entirely in the system pixel clock domain. The PS/2 lines are asynchronous inputs.

Parameters:
- SPACE_CODE, 8'h29, scan code treated as the jump key
- ESC_CODE, 8'h76, scan code producing esc_pulse
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before an in-progress frame is abandoned (1 ms at 50 MHz)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock, asynchronous
- ps2_data  input  1  raw PS/2 data, asynchronous
- byte_valid  output  1  one-cycle pulse: a good byte was received
- rx_byte  output  8  last good byte; valid when byte_valid=1
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error
- SpaceFlag  output  1  level: 1 while the space key is held
- space_pulse  output  1  one-cycle pulse on the space press (0→1 transition of SpaceFlag)
- esc_pulse  output  1  one-cycle pulse on an ESC make code

Behaviour:
- Reset values (async, rst=0): all outputs 0, FSM=IDLE, bit counter 0, timeout counter 0, break_pending=0, ext_pending=0. Both synchronizer chains reset to 1 (idle bus level).
- Synchronizer: 2-FF chain on ps2_clk and on ps2_data.
  - Falling edge = previous synced clk 1 and current synced clk 0.
  - Data is sampled only on that edge.
- FSM states and transitions:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bitcnt=0. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: on each edge, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on an edge, latch the parity bit and go to STOP.
  - STOP: on an edge, the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Good frame: rx_byte updated and byte_valid=1 on the cycle after the stop-bit edge.
    - Bad frame: frame_err=1 on that cycle, rx_byte unchanged.
    - Either way, return to IDLE.
- Timeout:
  - The counter clears on every falling edge and while in IDLE.
  - In any other state it increments each clk.
  - When it reaches TIMEOUT_CYCLES: FSM to IDLE, frame_err pulse, counter cleared, partial byte discarded, pending prefixes kept.
- Decode runs on the byte_valid cycle; its outputs register one cycle later.
  - F0: set break_pending.
  - E0: set ext_pending.
  - Any other code: act on it, then clear both pending flags.
  - SPACE_CODE with ext_pending=0:
    - SpaceFlag ← !break_pending.
    - space_pulse=1 only if this is a make code and SpaceFlag was 0. Typematic repeats of make 29 produce no further pulses.
  - ESC_CODE make with ext_pending=0: esc_pulse=1. ESC break codes are ignored.
  - Extended codes (E0 xx) never affect SpaceFlag or esc_pulse.
- Latency from the stop-bit falling edge on the raw pin:
  - 2 cycles of synchronizer plus 1 cycle to byte_valid.
  - SpaceFlag, space_pulse and esc_pulse follow 1 cycle after byte_valid.
- Simultaneous events: only one byte can complete per frame, so no arbitration is needed. A falling edge in the same cycle the timeout hits is processed as an edge; the timeout does not fire.
- Reset mid-frame: the frame is discarded and SpaceFlag is forced to 0, even if the key is physically still held. The next make 29 re-asserts SpaceFlag and pulses space_pulse.
- Pulses are exactly 1 cycle wide.

Test Plan:
- Frame 29, parity 0, stop 1 → byte_valid once with rx_byte=8'h29. Next cycle: SpaceFlag=1 and space_pulse=1 for 1 cycle.
- Frames 29, 29, 29 (typematic) then F0, 29 → exactly one space_pulse. SpaceFlag stays 1 until the cycle after the final byte, then goes 0. No frame_err.
- Frame 29 with wrong parity (parity=1) → frame_err pulse, byte_valid=0, SpaceFlag unchanged at 0.
- Start bit plus 4 data bits, then bus idle for TIMEOUT_CYCLES → frame_err at exactly TIMEOUT_CYCLES after the last edge, FSM IDLE. A following clean 29 frame sets SpaceFlag=1.
- Frames E0, 29 then 76 → SpaceFlag stays 0, no space_pulse. esc_pulse fires once after byte 76. F0, 76 → no esc_pulse.
- SpaceFlag=1, then rst low for 3 cycles mid-frame → all outputs 0 immediately (asynchronous). After release, a clean 29 frame gives space_pulse=1.
